// File: rtl/counter_seq_pkg.sv
// Shared types and defaults for the counter command sequencer.
package counter_seq_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_LOAD,
        OP_UP,
        OP_DOWN,
        OP_NOP
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/counter_cmd_sequencer.sv
// Turns load/up/down commands into control pins for the up/down loadable counter,
// optionally stopping at max/zero and reporting completion and step statistics.
module counter_cmd_sequencer
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             cmd_sat,
    input  logic             abort,
    input  logic             max_count,
    input  logic             zero,
    output logic             load_n,
    output logic             ce,
    output logic             up_down,
    output logic [WIDTH-1:0] data_load,
    output logic             busy,
    output logic             done,
    output logic             sat_hit,
    output logic [WIDTH-1:0] steps_done
);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0] steps_done_q, steps_done_d;
    logic             sat_hit_q, sat_hit_d;
    logic [WIDTH-1:0] data_load_q, data_load_d;
    logic             stop_c;

    // A running count halts on abort, or on the boundary it would otherwise wrap past.
    assign stop_c = abort
                 || (sat_q && (((op_q == OP_UP) && max_count) || ((op_q == OP_DOWN) && zero)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= OP_NOP;
            sat_q        <= 1'b0;
            remaining_q  <= '0;
            steps_done_q <= '0;
            sat_hit_q    <= 1'b0;
            data_load_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            sat_q        <= sat_d;
            remaining_q  <= remaining_d;
            steps_done_q <= steps_done_d;
            sat_hit_q    <= sat_hit_d;
            data_load_q  <= data_load_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        sat_d        = sat_q;
        remaining_d  = remaining_q;
        steps_done_d = steps_done_q;
        sat_hit_d    = sat_hit_q;
        data_load_d  = data_load_q;
        ce           = 1'b0;
        load_n       = 1'b1;
        up_down      = 1'b0;
        done         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d         = op_t'(cmd_op);
                    sat_d        = cmd_sat;
                    remaining_d  = cmd_arg;
                    steps_done_d = '0;
                    sat_hit_d    = 1'b0;
                    unique case (op_t'(cmd_op))
                        OP_LOAD: begin
                            data_load_d = cmd_arg;
                            state_d     = LOAD;
                        end
                        OP_UP, OP_DOWN: state_d = (cmd_arg != '0) ? RUN : DONE;
                        default:        state_d = DONE;
                    endcase
                end
            end
            LOAD: begin
                load_n  = 1'b0;
                state_d = DONE;
            end
            RUN: begin
                up_down = (op_q == OP_UP);
                if (stop_c) begin
                    sat_hit_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    ce           = 1'b1;
                    remaining_d  = remaining_q - WIDTH'(1);
                    steps_done_d = steps_done_q + WIDTH'(1);
                    if (remaining_q == WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign sat_hit    = sat_hit_q;
    assign steps_done = steps_done_q;
    assign data_load  = data_load_q;

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Bench for counter_cmd_sequencer driving a behavioural up/down loadable counter.
module tb_counter_cmd_sequencer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_arg;
    logic         cmd_sat;
    logic         abort;
    logic         max_count;
    logic         zero;
    logic         load_n;
    logic         ce;
    logic         up_down;
    logic [W-1:0] data_load;
    logic         busy;
    logic         done;
    logic         sat_hit;
    logic [W-1:0] steps_done;

    logic         rst_n;
    logic [W-1:0] count;
    logic [W-1:0] model_count;

    int passed = 0;
    int total  = 0;

    typedef struct {
        int           latency;
        int           ce_cycles;
        int           load_cycles;
        logic [W-1:0] steps;
        logic         sat;
        logic [W-1:0] count;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    counter_cmd_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .cmd_sat    (cmd_sat),
        .abort      (abort),
        .max_count  (max_count),
        .zero       (zero),
        .load_n     (load_n),
        .ce         (ce),
        .up_down    (up_down),
        .data_load  (data_load),
        .busy       (busy),
        .done       (done),
        .sat_hit    (sat_hit),
        .steps_done (steps_done)
    );

    // Counter being driven: active-low sync reset, load has priority over count.
    assign rst_n = ~rst;
    always_ff @(posedge clk) begin
        if (!rst_n)       count <= '0;
        else if (!load_n) count <= data_load;
        else if (ce)      count <= up_down ? count + 4'd1 : count - 4'd1;
    end
    assign max_count = (count == 4'hF);
    assign zero      = (count == 4'h0);

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd3; cmd_arg = '0; cmd_sat = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        model_count = '0;
        @(negedge clk); #1;
        total++; if (cmd_ready !== 1'b1) $display("FAIL reset cmd_ready got %b exp 1", cmd_ready); else passed++;
        total++; if (load_n !== 1'b1) $display("FAIL reset load_n got %b exp 1", load_n); else passed++;
        total++; if (ce !== 1'b0) $display("FAIL reset ce got %b exp 0", ce); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset done got %b exp 0", done); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset busy got %b exp 0", busy); else passed++;
        total++; if (steps_done !== 4'd0) $display("FAIL reset steps_done got %0d exp 0", steps_done); else passed++;
        total++; if (sat_hit !== 1'b0) $display("FAIL reset sat_hit got %b exp 0", sat_hit); else passed++;
        total++; if (data_load !== 4'd0) $display("FAIL reset data_load got %0d exp 0", data_load); else passed++;
    endtask

    // Issues one command; expectation is derived from the model and queued before driving.
    task automatic run_cmd(input string name, input logic [1:0] op, input logic [W-1:0] arg,
                           input logic sat, input int abort_cyc, input bit junk);
        exp_t e;
        exp_t got;
        int   cyc;
        int   ce_n;
        int   ld_n;
        int   bad_dir;
        int   bad_ld;
        bit   seen;
        bit   stopped;
        e.ce_cycles = 0; e.load_cycles = 0; e.steps = '0; e.sat = 1'b0;
        if (op == 2'd0) begin
            e.latency = 2; e.load_cycles = 1; model_count = arg;
        end else if (op == 2'd3) begin
            e.latency = 1;
        end else begin
            stopped = 1'b0;
            cyc = 1;
            for (int k = 0; k < int'(arg) && !stopped; k++) begin
                if (cyc == abort_cyc || (sat && op == 2'd1 && model_count == 4'hF)
                                      || (sat && op == 2'd2 && model_count == 4'h0)) begin
                    stopped = 1'b1;
                    e.sat   = 1'b1;
                end else begin
                    model_count = (op == 2'd1) ? model_count + 4'd1 : model_count - 4'd1;
                    e.ce_cycles++;
                    cyc++;
                end
            end
            e.steps   = 4'(e.ce_cycles);
            e.latency = stopped ? cyc + 1 : cyc;
        end
        e.count = model_count;
        sb.push_back(e);

        @(negedge clk); #1;
        total++; if (cmd_ready !== 1'b1) $display("FAIL %s ready_before got %b exp 1", name, cmd_ready); else passed++;
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; cmd_sat = sat;
        @(posedge clk);
        ce_n = 0; ld_n = 0; bad_dir = 0; bad_ld = 0; seen = 1'b0; cyc = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            abort = (c == abort_cyc);
            if (junk) begin
                cmd_valid = 1'b1; cmd_op = 2'($urandom_range(0, 3)); cmd_arg = 4'($urandom);
                cmd_sat = 1'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            #1;
            if (ce) begin
                ce_n++;
                if (up_down !== (op == 2'd1)) bad_dir++;
            end
            if (!load_n) begin
                ld_n++;
                if (data_load !== arg) bad_ld++;
            end
            if (done) begin
                seen = 1'b1;
                cyc  = c;
            end
        end
        cmd_valid = 1'b0; abort = 1'b0;

        got = sb.pop_front();
        total++; if (!seen) $display("FAIL %s done_timeout got none exp cycle %0d", name, got.latency); else passed++;
        total++; if (cyc != got.latency) $display("FAIL %s latency got %0d exp %0d", name, cyc, got.latency); else passed++;
        total++; if (ce_n != got.ce_cycles) $display("FAIL %s ce_cycles got %0d exp %0d", name, ce_n, got.ce_cycles); else passed++;
        total++; if (ld_n != got.load_cycles) $display("FAIL %s load_cycles got %0d exp %0d", name, ld_n, got.load_cycles); else passed++;
        total++; if (bad_dir != 0 || bad_ld != 0) $display("FAIL %s pins bad_dir %0d bad_load %0d exp 0 0", name, bad_dir, bad_ld); else passed++;
        total++; if (steps_done !== got.steps) $display("FAIL %s steps_done got %0d exp %0d", name, steps_done, got.steps); else passed++;
        total++; if (sat_hit !== got.sat) $display("FAIL %s sat_hit got %b exp %b", name, sat_hit, got.sat); else passed++;
        total++; if (count !== got.count) $display("FAIL %s count got %0d exp %0d", name, count, got.count); else passed++;
        @(negedge clk); #1;
        total++; if (cmd_ready !== 1'b1 || done !== 1'b0) $display("FAIL %s after ready %b done %b exp 1 0", name, cmd_ready, done); else passed++;
    endtask

    task automatic test_load();
        run_cmd("load_a", 2'd0, 4'hA, 1'b0, 0, 1'b0);
    endtask

    task automatic test_count_up();
        run_cmd("up3", 2'd1, 4'd3, 1'b0, 0, 1'b0);
    endtask

    task automatic test_saturate();
        run_cmd("up5_sat", 2'd1, 4'd5, 1'b1, 0, 1'b0);
        run_cmd("up3_wrap", 2'd1, 4'd3, 1'b0, 0, 1'b0);
        run_cmd("load_1", 2'd0, 4'd1, 1'b0, 0, 1'b0);
        run_cmd("down4_sat", 2'd2, 4'd4, 1'b1, 0, 1'b0);
    endtask

    task automatic test_zero_and_busy();
        run_cmd("down0", 2'd2, 4'd0, 1'b0, 0, 1'b1);
        run_cmd("nop", 2'd3, 4'd7, 1'b0, 0, 1'b1);
        run_cmd("up6_busy", 2'd1, 4'd6, 1'b0, 0, 1'b1);
        run_cmd("load_busy", 2'd0, 4'h5, 1'b0, 0, 1'b1);
    endtask

    task automatic test_abort();
        run_cmd("load_f", 2'd0, 4'hF, 1'b0, 0, 1'b0);
        run_cmd("down8_abort", 2'd2, 4'd8, 1'b0, 3, 1'b0);
    endtask

    task automatic test_reset_mid();
        int dn;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_arg = 4'd8; cmd_sat = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            rst = (c == 3);
        end
        @(negedge clk); #1;
        total++; if (ce !== 1'b0 || load_n !== 1'b1) $display("FAIL rst_mid pins ce %b load_n %b exp 0 1", ce, load_n); else passed++;
        total++; if (busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL rst_mid state busy %b ready %b exp 0 1", busy, cmd_ready); else passed++;
        rst = 1'b0;
        model_count = '0;
        dn = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (done) dn++;
        end
        total++; if (dn != 0 || done !== 1'b0) $display("FAIL rst_mid done got %0d pulses exp 0", dn); else passed++;
        total++; if (count !== 4'd0) $display("FAIL rst_mid count got %0d exp 0", count); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [1:0]   op;
        logic [W-1:0] arg;
        logic         sat;
        int           ab;
        for (int i = 0; i < 10; i++) begin
            op  = 2'($urandom_range(0, 3));
            arg = 4'($urandom);
            sat = 1'($urandom);
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_cmd("rand", op, arg, sat, ab, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_count_up();
        test_saturate();
        test_zero_and_busy();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
